// File: rtl/cpu_dp_pipe_if.sv
// Instruction-in / result-out bundle for cpu_dp_pipe.
// The master side is the sequencer plus the result consumer; the slave side is the datapath.
interface cpu_dp_pipe_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [AW-1:0]    ra;
  logic [AW-1:0]    rb;
  logic [AW-1:0]    rd;
  logic             asel;
  logic             bsel;
  logic             we;
  logic [WIDTH-1:0] data_in;
  logic             oen;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, op, ra, rb, rd, asel, bsel, we, data_in, oen, out_ready,
    input  in_ready, out_valid, result, ovf, zero
  );

  modport slave (
    input  in_valid, op, ra, rb, rd, asel, bsel, we, data_in, oen, out_ready,
    output in_ready, out_valid, result, ovf, zero
  );
endinterface

// File: rtl/cpu_dp_pipe.sv
// Two-stage register-file datapath: S1 holds operands, S2 holds the registered ALU result.
// S1's result is written back and forwarded to the next instruction's operands on the same edge.
module cpu_dp_pipe #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = $clog2(DEPTH),
  parameter bit RF_RESET = 1'b1
) (
  input logic           clk,
  input logic           rst_n,
  cpu_dp_pipe_if.slave  dp
);

  typedef enum logic [2:0] {
    OP_LOAD = 3'b000,
    OP_ADD  = 3'b001,
    OP_SUB  = 3'b010,
    OP_AND  = 3'b011,
    OP_OR   = 3'b100,
    OP_XOR  = 3'b101,
    OP_CMP  = 3'b110,
    OP_READ = 3'b111
  } op_e;

  logic [WIDTH-1:0] r_rf [DEPTH];

  logic             r_s1_valid;
  op_e              r_s1_op;
  logic [AW-1:0]    r_s1_rd;
  logic             r_s1_we;
  logic             r_s1_oen;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_ovf;
  logic             r_zero;

  logic             w_stall;
  logic             w_accept;
  logic             w_s1_adv;
  logic             w_rf_we;
  logic             w_byp_a;
  logic             w_byp_b;
  logic [WIDTH-1:0] w_op_a;
  logic [WIDTH-1:0] w_op_b;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_ovf;
  logic             w_lt;
  logic             w_eq;
  logic             w_gt;

  assign w_stall  = r_out_valid && !dp.out_ready;
  assign w_accept = dp.in_valid && !w_stall;
  assign w_s1_adv = r_s1_valid && !w_stall;
  assign w_rf_we  = w_s1_adv && r_s1_we;

  // Forward only when the write actually lands this edge, so the RF and bypass never disagree.
  assign w_byp_a = w_rf_we && (r_s1_rd == dp.ra);
  assign w_byp_b = w_rf_we && (r_s1_rd == dp.rb);
  assign w_op_a  = dp.asel ? (w_byp_a ? w_alu_res : r_rf[dp.ra]) : dp.data_in;
  assign w_op_b  = dp.bsel ? (w_byp_b ? w_alu_res : r_rf[dp.rb]) : dp.data_in;

  assign w_sum  = r_s1_a + r_s1_b;
  assign w_diff = r_s1_a - r_s1_b;
  assign w_lt   = $signed(r_s1_a) < $signed(r_s1_b);
  assign w_eq   = r_s1_a == r_s1_b;
  assign w_gt   = $signed(r_s1_a) > $signed(r_s1_b);

  always_comb begin
    w_alu_res = '0;
    w_alu_ovf = 1'b0;
    case (r_s1_op)
      OP_LOAD: w_alu_res = r_s1_b;
      OP_ADD: begin
        w_alu_res = w_sum;
        w_alu_ovf = (r_s1_a[WIDTH-1] == r_s1_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_s1_a[WIDTH-1]);
      end
      OP_SUB: begin
        w_alu_res = w_diff;
        w_alu_ovf = (r_s1_a[WIDTH-1] != r_s1_b[WIDTH-1]) && (w_diff[WIDTH-1] != r_s1_a[WIDTH-1]);
      end
      OP_AND:  w_alu_res = r_s1_a & r_s1_b;
      OP_OR:   w_alu_res = r_s1_a | r_s1_b;
      OP_XOR:  w_alu_res = r_s1_a ^ r_s1_b;
      OP_CMP:  w_alu_res = {{(WIDTH-3){1'b0}}, w_gt, w_eq, w_lt};
      OP_READ: w_alu_res = r_s1_a;
      default: w_alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= OP_LOAD;
      r_s1_rd    <= '0;
      r_s1_we    <= 1'b0;
      r_s1_oen   <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
    end else if (!w_stall) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_op  <= op_e'(dp.op);
        r_s1_rd  <= dp.rd;
        r_s1_we  <= dp.we;
        r_s1_oen <= dp.oen;
        r_s1_a   <= w_op_a;
        r_s1_b   <= w_op_b;
      end
    end
  end

  // Result fields keep their last value when S1 is empty; out_valid qualifies them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
    end else if (!w_stall) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_result <= r_s1_oen ? w_alu_res : '0;
        r_ovf    <= w_alu_ovf;
        r_zero   <= (w_alu_res == '0);
      end
    end
  end

  generate
    if (RF_RESET) begin : g_rf_rst
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) r_rf[i] <= '0;
        end else if (w_rf_we) begin
          r_rf[r_s1_rd] <= w_alu_res;
        end
      end
    end else begin : g_rf_norst
      always_ff @(posedge clk) begin
        if (w_rf_we) r_rf[r_s1_rd] <= w_alu_res;
      end
    end
  endgenerate

  assign dp.in_ready  = !w_stall;
  assign dp.out_valid = r_out_valid;
  assign dp.result    = r_result;
  assign dp.ovf       = r_ovf;
  assign dp.zero      = r_zero;

endmodule
